nn_inference_sequencer: RTL and testbench

Front-end controller for the 4-layer dense/ReLU/softmax inference pipeline. It accepts input frames from a host over a valid/ready handshake, issues single-cycle start pulses to the network, and enforces the network's initiation interval and a credit limit. It captures each result when the network signals done and buffers it in a result FIFO. It presents each result downstream with an argmax class index, and recovers from a hung network via a watchdog.

---
 rtl/nn_seq_pkg.sv | 18 +
 rtl/nn_result_fifo.sv | 45 ++++
 rtl/nn_inference_sequencer.sv | 81 ++++++++
 tb/tb_nn_inference_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_seq_pkg.sv
// nn_seq_pkg: shared sizes, FSM state, frame types and argmax helper for the inference sequencer
package nn_seq_pkg;
  localparam int WIDTH       = 4;
  localparam int NFRAC       = 2;
  localparam int INPUT_SIZE  = 16;
  localparam int OUTPUT_SIZE = 5;
  localparam int CLS_W       = $clog2(OUTPUT_SIZE);
  typedef enum logic {RUN, HALT} seq_state_t;
  typedef logic signed [WIDTH-1:0] frame_in_t [INPUT_SIZE];
  typedef logic signed [WIDTH-1:0] frame_out_t [OUTPUT_SIZE];
  function automatic logic [CLS_W-1:0] argmax_idx(input frame_out_t f);
    logic [CLS_W-1:0] idx;
    idx = '0;
    for (int i = 1; i < OUTPUT_SIZE; i++)
      if (f[i] > f[idx]) idx = CLS_W'(i);
    return idx;
  endfunction
endpackage

// File: rtl/nn_result_fifo.sv
// nn_result_fifo: first-word fall-through result FIFO (ports: clk/reset, push/din, pop/dout, count/full/empty; dout is zero when empty)
module nn_result_fifo #(
  parameter int WIDTH       = 4,
  parameter int OUTPUT_SIZE = 5,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                push,
  input  logic                                pop,
  input  logic signed [WIDTH-1:0]             din [OUTPUT_SIZE],
  output logic signed [WIDTH-1:0]             dout [OUTPUT_SIZE],
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     count,
  output logic                                full,
  output logic                                empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  logic signed [WIDTH-1:0] r_mem [FIFO_DEPTH][OUTPUT_SIZE];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_push, w_pop;
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || pop);
  assign count  = r_count;
  assign full   = r_count == CW'(FIFO_DEPTH);
  assign empty  = r_count == '0;
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  always_comb begin
    for (int i = 0; i < OUTPUT_SIZE; i++) dout[i] = empty ? '0 : r_mem[r_rd][i];
  end
endmodule

// File: rtl/nn_inference_sequencer.sv
// nn_inference_sequencer: issues host frames to the network under gap/credit limits, buffers results with argmax, watchdog halts on hang (ports: in_* host, nn_* network, out_* results, inflight/error/clear_error status)
module nn_inference_sequencer
  import nn_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ISSUE_GAP  = 1,
  parameter int TIMEOUT    = 1024
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  frame_in_t                        in_data,
  output logic                             nn_input_ready,
  output frame_in_t                        nn_input_data,
  input  logic                             nn_output_ready,
  input  frame_out_t                       nn_output_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output frame_out_t                       out_data,
  output logic [CLS_W-1:0]                 out_class,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  inflight,
  output logic                             error,
  input  logic                             clear_error
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int GW = $clog2(ISSUE_GAP+1);
  localparam int WW = $clog2(TIMEOUT);
  seq_state_t r_state;
  logic r_issue, r_error;
  frame_in_t r_frame;
  logic [GW-1:0] r_gap;
  logic [WW-1:0] r_wd;
  logic [CW-1:0] r_inflight, w_count;
  logic w_full, w_empty, w_accept, w_capture, w_timeout;
  assign in_ready  = !reset && r_state == RUN && r_gap == '0 && !w_full &&
                     ({1'b0, r_inflight} + {1'b0, w_count}) < (CW+1)'(FIFO_DEPTH);
  assign w_accept  = in_valid && in_ready;
  assign w_capture = nn_output_ready && r_state == RUN && r_inflight != '0;
  assign w_timeout = r_state == RUN && r_inflight != '0 && !w_capture && r_wd == WW'(TIMEOUT-1);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN;
      r_issue    <= 1'b0;
      r_error    <= 1'b0;
      r_frame    <= '{default: '0};
      r_gap      <= '0;
      r_wd       <= '0;
      r_inflight <= '0;
    end else begin
      r_issue    <= w_accept;
      if (w_accept) r_frame <= in_data;
      r_gap      <= w_accept ? GW'(ISSUE_GAP-1) : (r_gap != '0 ? r_gap - GW'(1) : r_gap);
      r_wd       <= (r_state != RUN || r_inflight == '0 || w_capture || w_timeout) ? '0 : r_wd + WW'(1);
      r_inflight <= w_timeout ? '0 : r_inflight + CW'(w_accept) - CW'(w_capture);
      r_state    <= w_timeout ? HALT : (clear_error ? RUN : r_state);
      r_error    <= w_timeout ? 1'b1 : (clear_error && r_state == HALT ? 1'b0 : r_error);
    end
  end
  nn_result_fifo #(
    .WIDTH(WIDTH),
    .OUTPUT_SIZE(OUTPUT_SIZE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(w_capture),
    .pop(out_valid && out_ready),
    .din(nn_output_data),
    .dout(out_data),
    .count(w_count),
    .full(w_full),
    .empty(w_empty)
  );
  assign out_valid      = !w_empty;
  assign out_class      = argmax_idx(out_data);
  assign nn_input_ready = r_issue;
  assign nn_input_data  = r_frame;
  assign inflight       = r_inflight;
  assign error          = r_error;
endmodule

// File: tb/tb_nn_inference_sequencer.sv
// tb_nn_inference_sequencer: directed self-checking bench for the inference sequencer
module tb_nn_inference_sequencer;
  import nn_seq_pkg::*;
  logic clk = 1'b0;
  logic reset, in_valid, nn_output_ready, out_ready, clear_error;
  frame_in_t in_data;
  frame_out_t nn_out_data;
  logic a_in_ready, a_pulse, a_out_valid, a_error;
  frame_in_t a_nn_data;
  frame_out_t a_out_data;
  logic [2:0] a_class, a_inflight;
  logic b_in_ready, b_pulse, b_out_valid, b_error;
  frame_in_t b_nn_data;
  frame_out_t b_out_data;
  logic [2:0] b_class, b_inflight;
  int checks = 0;
  int errors = 0;
  logic [8:0] gap_rdy = 9'b001001001;
  logic [8:0] gap_pls = 9'b010010010;
  always #5 clk = ~clk;
  nn_inference_sequencer #(.FIFO_DEPTH(4), .ISSUE_GAP(1), .TIMEOUT(16)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .nn_input_ready(a_pulse), .nn_input_data(a_nn_data), .nn_output_ready(nn_output_ready),
    .nn_output_data(nn_out_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_class(a_class), .inflight(a_inflight), .error(a_error),
    .clear_error(clear_error)
  );
  nn_inference_sequencer #(.FIFO_DEPTH(4), .ISSUE_GAP(3), .TIMEOUT(16)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .nn_input_ready(b_pulse), .nn_input_data(b_nn_data), .nn_output_ready(nn_output_ready),
    .nn_output_data(nn_out_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_class(b_class), .inflight(b_inflight), .error(b_error),
    .clear_error(clear_error)
  );
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask
  task automatic set_res(input int v0, input int v1, input int v2, input int v3, input int v4);
    nn_out_data[0] = 4'(v0);
    nn_out_data[1] = 4'(v1);
    nn_out_data[2] = 4'(v2);
    nn_out_data[3] = 4'(v3);
    nn_out_data[4] = 4'(v4);
  endtask
  initial begin
    reset = 1'b1; in_valid = 1'b0; nn_output_ready = 1'b0; out_ready = 1'b1; clear_error = 1'b0;
    for (int i = 0; i < INPUT_SIZE; i++) in_data[i] = 4'(i);
    set_res(0, 0, 0, 0, 0);
    step; step;
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_pulse", a_pulse, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_inflight", a_inflight, 0);
    chk("rst_error", a_error, 0);
    chk("rst_class", a_class, 0);
    chk("rst_nn_data", a_nn_data[3], 0);
    chk("rst_out_data", a_out_data[0], 0);
    reset = 1'b0;
    step;
    chk("idle_in_ready", a_in_ready, 1);
    // single frame through the network
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    chk("t1_pulse", a_pulse, 1);
    chk("t1_inflight", a_inflight, 1);
    chk("t1_nn_data7", a_nn_data[7], 7);
    chk("t1_nn_data15", a_nn_data[15], -1);
    step;
    chk("t1_pulse_once", a_pulse, 0);
    repeat (4) step;
    set_res(1, -2, 3, 3, 0);
    nn_output_ready = 1'b1;
    chk("t1_pre_valid", a_out_valid, 0);
    step;
    nn_output_ready = 1'b0;
    chk("t1_out_valid", a_out_valid, 1);
    chk("t1_class_tie", a_class, 2);
    chk("t1_out_data1", a_out_data[1], -2);
    chk("t1_inflight0", a_inflight, 0);
    step;
    chk("t1_popped", a_out_valid, 0);
    // credit limit with a stalled consumer
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (4) step;
    chk("cr_inflight4", a_inflight, 4);
    chk("cr_in_ready0", a_in_ready, 0);
    for (int k = 0; k < 4; k++) begin
      set_res(0, 0, 0, 0, 0);
      nn_out_data[k] = 4'sd3;
      nn_output_ready = 1'b1;
      step;
    end
    nn_output_ready = 1'b0;
    chk("cr_full_inflight", a_inflight, 0);
    chk("cr_full_in_ready", a_in_ready, 0);
    chk("cr_full_valid", a_out_valid, 1);
    chk("cr_full_class", a_class, 0);
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    chk("cr_pop_in_ready", a_in_ready, 1);
    chk("cr_pop_class", a_class, 1);
    step;
    in_valid = 1'b0;
    chk("cr_extra_pulse", a_pulse, 1);
    chk("cr_extra_inflight", a_inflight, 1);
    chk("cr_extra_in_ready", a_in_ready, 0);
    out_ready = 1'b1;
    step;
    chk("dr_class2", a_class, 2);
    step;
    chk("dr_class3", a_class, 3);
    step;
    chk("dr_empty", a_out_valid, 0);
    out_ready = 1'b0;
    // issue and capture in the same cycle
    in_valid = 1'b1;
    step;
    chk("sc_inflight2", a_inflight, 2);
    set_res(1, -8, -3, -8, -2);
    nn_output_ready = 1'b1;
    step;
    in_valid = 1'b0;
    nn_output_ready = 1'b0;
    chk("sc_inflight", a_inflight, 2);
    chk("sc_out_valid", a_out_valid, 1);
    chk("sc_class_signed", a_class, 0);
    chk("sc_pulse", a_pulse, 1);
    // watchdog: no response after the last start pulse
    repeat (15) step;
    chk("wd_pre_error", a_error, 0);
    chk("wd_pre_inflight", a_inflight, 2);
    step;
    chk("wd_error", a_error, 1);
    chk("wd_inflight", a_inflight, 0);
    chk("wd_in_ready", a_in_ready, 0);
    set_res(0, 0, 3, 0, 0);
    nn_output_ready = 1'b1;
    step;
    nn_output_ready = 1'b0;
    chk("halt_error", a_error, 1);
    chk("halt_inflight", a_inflight, 0);
    chk("halt_class", a_class, 0);
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    chk("halt_drained", a_out_valid, 0);
    clear_error = 1'b1;
    step;
    clear_error = 1'b0;
    chk("clr_error", a_error, 0);
    chk("clr_in_ready", a_in_ready, 1);
    // reset with frames in flight and a buffered result
    in_valid = 1'b1;
    repeat (3) step;
    in_valid = 1'b0;
    set_res(0, 3, 0, 0, 0);
    nn_output_ready = 1'b1;
    step;
    chk("mr_pre_inflight", a_inflight, 2);
    chk("mr_pre_valid", a_out_valid, 1);
    reset = 1'b1;
    step;
    nn_output_ready = 1'b0;
    chk("mr_out_valid", a_out_valid, 0);
    chk("mr_inflight", a_inflight, 0);
    chk("mr_error", a_error, 0);
    chk("mr_pulse", a_pulse, 0);
    chk("mr_nn_data", a_nn_data[7], 0);
    reset = 1'b0;
    step;
    chk("mr_post_valid", a_out_valid, 0);
    chk("mr_post_in_ready", a_in_ready, 1);
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    chk("mr_new_pulse", a_pulse, 1);
    chk("mr_new_inflight", a_inflight, 1);
    set_res(0, 0, 0, 3, 0);
    nn_output_ready = 1'b1;
    step;
    nn_output_ready = 1'b0;
    chk("mr_new_valid", a_out_valid, 1);
    chk("mr_new_class", a_class, 3);
    chk("mr_new_inflight0", a_inflight, 0);
    // issue gap of 3 on the second instance
    out_ready = 1'b1;
    reset = 1'b1;
    step;
    reset = 1'b0;
    in_valid = 1'b1;
    #1;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("gap_in_ready_%0d", k), b_in_ready, 32'(gap_rdy[k]));
      chk($sformatf("gap_pulse_%0d", k), b_pulse, 32'(gap_pls[k]));
      step;
    end
    in_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
